decode_stage_pipelined: RTL and testbench

- Parametrised MIPS-style instruction decode stage with an integrated ID/EX pipeline register.
- Sits between the IF/ID register and the execute stage. The main controller drives its control bundle in through ctrl_in.
- Contains the register file with write-through bypass, load-use hazard detection with stall/bubble insertion, flush/hold handling, immediate extension, registered branch/jump targets and a registered early operand compare.

---
 rtl/decode_stage_pipelined.sv | 155 +++++++++++++++
 tb/tb_decode_stage_pipelined.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: MIPS-style decode with register file, load-use hazard
// detection and ID/EX register. Define DECODE_PERF_EN to add stall/flush counters.
module decode_stage_pipelined #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  if_valid,
    input  logic [31:0]           instr_in,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    input  logic                  ctrl_mem_read_in,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    input  logic                  ex_hold,
    output logic                  stall,
    output logic                  id_ex_valid,
    output logic [CTRL_W-1:0]     id_ex_ctrl,
    output logic                  id_ex_mem_read,
    output logic [XLEN-1:0]       id_ex_rs_data,
    output logic [XLEN-1:0]       id_ex_rt_data,
    output logic [XLEN-1:0]       id_ex_imm,
    output logic [REG_ADDR_W-1:0] id_ex_rs,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [4:0]            id_ex_shamt,
    output logic [5:0]            id_ex_funct,
    output logic [5:0]            id_ex_opcode,
    output logic [XLEN-1:0]       id_ex_pc,
    output logic [XLEN-1:0]       id_ex_branch_target,
    output logic [XLEN-1:0]       id_ex_jump_target,
    output logic                  id_ex_eq,
    output logic                  id_ex_lt,
    output logic                  id_ex_gt
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [5:0]            opcode;
    logic [XLEN-1:0]       rs_data, rt_data, imm, branch_target, jump_target;
    logic                  zext, eq, lt, gt, hz;
    logic [XLEN-1:0]       regs [NREGS];

    assign rs     = instr_in[21 +: REG_ADDR_W];
    assign rt     = instr_in[16 +: REG_ADDR_W];
    assign rd     = instr_in[11 +: REG_ADDR_W];
    assign opcode = instr_in[31:26];

    // NOTE: the register array is reset explicitly because every entry must read 0 after Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_reg_write && wb_reg != '0) begin
            regs[wb_reg] <= wb_data;
        end
    end

    // Write-through read: a register written this cycle is visible to the instruction in ID.
    assign rs_data = (rs == '0) ? '0 : (wb_reg_write && wb_reg == rs) ? wb_data : regs[rs];
    assign rt_data = (rt == '0) ? '0 : (wb_reg_write && wb_reg == rt) ? wb_data : regs[rt];

    // andi/ori/xori take a zero-extended immediate; everything else sign-extends.
    assign zext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
    assign imm  = zext ? {{(XLEN-16){1'b0}}, instr_in[15:0]}
                       : {{(XLEN-16){instr_in[15]}}, instr_in[15:0]};

    assign branch_target = pc_in + (imm << 2);
    assign jump_target   = {pc_in[XLEN-1:28], instr_in[25:0], 2'b00};

    assign eq = (rs_data == rt_data);
    assign lt = ($signed(rs_data) < $signed(rt_data));
    assign gt = ($signed(rs_data) > $signed(rt_data));

    assign hz = if_valid && id_ex_valid && id_ex_mem_read && (id_ex_rt != '0) &&
                ((id_ex_rt == rs) || (id_ex_rt == rt));

    assign stall = !flush && (ex_hold || hz);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            id_ex_valid         <= 1'b0;
            id_ex_ctrl          <= '0;
            id_ex_mem_read      <= 1'b0;
            id_ex_rs_data       <= '0;
            id_ex_rt_data       <= '0;
            id_ex_imm           <= '0;
            id_ex_rs            <= '0;
            id_ex_rt            <= '0;
            id_ex_rd            <= '0;
            id_ex_shamt         <= '0;
            id_ex_funct         <= '0;
            id_ex_opcode        <= '0;
            id_ex_pc            <= '0;
            id_ex_branch_target <= '0;
            id_ex_jump_target   <= '0;
            id_ex_eq            <= 1'b0;
            id_ex_lt            <= 1'b0;
            id_ex_gt            <= 1'b0;
        end else begin
            // Datapath fields load on bubbles too, so they stay deterministic.
            if (flush || !ex_hold) begin
                id_ex_rs_data       <= rs_data;
                id_ex_rt_data       <= rt_data;
                id_ex_imm           <= imm;
                id_ex_rs            <= rs;
                id_ex_rt            <= rt;
                id_ex_rd            <= rd;
                id_ex_shamt         <= instr_in[10:6];
                id_ex_funct         <= instr_in[5:0];
                id_ex_opcode        <= opcode;
                id_ex_pc            <= pc_in;
                id_ex_branch_target <= branch_target;
                id_ex_jump_target   <= jump_target;
            end
            if (flush || (!ex_hold && hz)) begin
                id_ex_valid    <= 1'b0;
                id_ex_ctrl     <= '0;
                id_ex_mem_read <= 1'b0;
                id_ex_eq       <= 1'b0;
                id_ex_lt       <= 1'b0;
                id_ex_gt       <= 1'b0;
            end else if (!ex_hold) begin
                id_ex_valid    <= if_valid;
                id_ex_ctrl     <= if_valid ? ctrl_in : '0;
                id_ex_mem_read <= if_valid && ctrl_mem_read_in;
                id_ex_eq       <= eq;
                id_ex_lt       <= lt;
                id_ex_gt       <= gt;
            end
        end
    end

`ifdef DECODE_PERF_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (hz && !flush && !ex_hold && stall_count != '1) stall_count <= stall_count + 32'd1;
            if (flush && flush_count != '1) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb_decode_stage_pipelined: scoreboard bench; a reference model predicts each ID/EX
// state when stimulus is applied, and the prediction is compared after the edge.
module tb_decode_stage_pipelined;

    typedef struct packed {
        logic        valid;
        logic [15:0] ctrl;
        logic        mr;
        logic [31:0] rs_d, rt_d, imm, pc, bt, jt;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct, opc;
        logic        eq, lt, gt;
    } idex_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        if_valid;
    logic [31:0] instr_in, pc_in, wb_data;
    logic [15:0] ctrl_in;
    logic        ctrl_mem_read_in, wb_reg_write, flush, ex_hold;
    logic [4:0]  wb_reg;
    logic        stall, id_ex_valid, id_ex_mem_read, id_ex_eq, id_ex_lt, id_ex_gt;
    logic [15:0] id_ex_ctrl;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc;
    logic [31:0] id_ex_branch_target, id_ex_jump_target;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
    logic [5:0]  id_ex_funct, id_ex_opcode;
`ifdef DECODE_PERF_EN
    logic [31:0] stall_count, flush_count;
    int          m_stall_cnt = 0, m_flush_cnt = 0;
`endif

    int          n_vec = 0, n_err = 0;
    logic        last_stall;
    idex_t       cur = '0;
    idex_t       exp_q[$];
    logic [31:0] mregs [32];

    always #5 Clk = ~Clk;

    decode_stage_pipelined dut (
        .Clk(Clk), .Reset(Reset), .if_valid(if_valid), .instr_in(instr_in), .pc_in(pc_in),
        .ctrl_in(ctrl_in), .ctrl_mem_read_in(ctrl_mem_read_in), .wb_reg_write(wb_reg_write),
        .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush), .ex_hold(ex_hold), .stall(stall),
        .id_ex_valid(id_ex_valid), .id_ex_ctrl(id_ex_ctrl), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_shamt(id_ex_shamt),
        .id_ex_funct(id_ex_funct), .id_ex_opcode(id_ex_opcode), .id_ex_pc(id_ex_pc),
        .id_ex_branch_target(id_ex_branch_target), .id_ex_jump_target(id_ex_jump_target),
        .id_ex_eq(id_ex_eq), .id_ex_lt(id_ex_lt), .id_ex_gt(id_ex_gt)
`ifdef DECODE_PERF_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_reg_write && wb_reg == a) return wb_data;
        return mregs[a];
    endfunction

    task automatic set_idle();
        if_valid = 1'b0; instr_in = '0; pc_in = '0; ctrl_in = '0; ctrl_mem_read_in = 1'b0;
        wb_reg_write = 1'b0; wb_reg = '0; wb_data = '0; flush = 1'b0; ex_hold = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [15:0] ctrl, input logic mr);
        if_valid = 1'b1; instr_in = instr; pc_in = pc; ctrl_in = ctrl; ctrl_mem_read_in = mr;
    endtask

    task automatic compare_all(input idex_t e);
        check("valid", 32'(id_ex_valid), 32'(e.valid));
        check("ctrl", 32'(id_ex_ctrl), 32'(e.ctrl));
        check("mem_read", 32'(id_ex_mem_read), 32'(e.mr));
        check("rs_data", id_ex_rs_data, e.rs_d);
        check("rt_data", id_ex_rt_data, e.rt_d);
        check("imm", id_ex_imm, e.imm);
        check("pc", id_ex_pc, e.pc);
        check("branch_target", id_ex_branch_target, e.bt);
        check("jump_target", id_ex_jump_target, e.jt);
        check("fields", {7'd0, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt},
                        {7'd0, e.rs, e.rt, e.rd, e.shamt});
        check("funct_opcode", {20'd0, id_ex_funct, id_ex_opcode}, {20'd0, e.funct, e.opc});
        check("cmp", {29'd0, id_ex_eq, id_ex_lt, id_ex_gt}, {29'd0, e.eq, e.lt, e.gt});
    endtask

    // One clock: predict at negedge, compare after the following posedge.
    task automatic step();
        idex_t       d, n, e;
        logic [4:0]  rs, rt;
        logic        hz, zx;
        @(negedge Clk);
        rs = instr_in[25:21];
        rt = instr_in[20:16];
        hz = if_valid && cur.valid && cur.mr && cur.rt != 5'd0 && (cur.rt == rs || cur.rt == rt);
        last_stall = stall;
        check("stall", 32'(stall), 32'(!flush && (ex_hold || hz)));
        zx = instr_in[31:26] inside {6'h0C, 6'h0D, 6'h0E};
        d       = '0;
        d.rs_d  = rdreg(rs);
        d.rt_d  = rdreg(rt);
        d.imm   = zx ? {16'h0, instr_in[15:0]} : {{16{instr_in[15]}}, instr_in[15:0]};
        d.pc    = pc_in;
        d.bt    = pc_in + {d.imm[29:0], 2'b00};
        d.jt    = {pc_in[31:28], instr_in[25:0], 2'b00};
        d.rs    = rs;
        d.rt    = rt;
        d.rd    = instr_in[15:11];
        d.shamt = instr_in[10:6];
        d.funct = instr_in[5:0];
        d.opc   = instr_in[31:26];
        if (Reset) n = '0;
        else if (flush || (!ex_hold && hz)) n = d;
        else if (ex_hold) n = cur;
        else begin
            n       = d;
            n.valid = if_valid;
            n.ctrl  = if_valid ? ctrl_in : 16'h0;
            n.mr    = if_valid && ctrl_mem_read_in;
            n.eq    = (d.rs_d == d.rt_d);
            n.lt    = ($signed(d.rs_d) < $signed(d.rt_d));
            n.gt    = ($signed(d.rs_d) > $signed(d.rt_d));
        end
`ifdef DECODE_PERF_EN
        if (Reset) begin
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (hz && !flush && !ex_hold) m_stall_cnt++;
            if (flush) m_flush_cnt++;
        end
`endif
        exp_q.push_back(n);
        cur = n;
        if (Reset) for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        else if (wb_reg_write && wb_reg != 5'd0) mregs[wb_reg] = wb_data;
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        compare_all(e);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        set_idle();
        Reset = 1'b1;
        step();
        step();
        check("rst_valid", 32'(id_ex_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        Reset = 1'b0;

        // Register writes, including a discarded write to r0.
        wb_reg_write = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234; step();
        wb_reg = 5'd0; wb_data = 32'hFFFF; step();
        wb_reg_write = 1'b0;
        issue(r_type(5'd5, 5'd0, 5'd1, 6'h20), 32'h4, 16'h0001, 1'b0); step();
        check("rf_read_r5", id_ex_rs_data, 32'h1234);
        check("rf_r0_zero", id_ex_rt_data, 32'h0);

        // Same-cycle write-through.
        wb_reg_write = 1'b1; wb_reg = 5'd3; wb_data = 32'hCAFE;
        issue(r_type(5'd3, 5'd5, 5'd2, 6'h20), 32'h8, 16'h0001, 1'b0); step();
        check("bypass_rs", id_ex_rs_data, 32'hCAFE);
        wb_reg_write = 1'b0;

        // Load-use: lw r8 then add rs=8 -> one bubble, then the add.
        issue(i_type(6'h23, 5'd0, 5'd8, 16'h4), 32'hC, 16'h0023, 1'b1); step();
        issue(r_type(5'd8, 5'd1, 5'd3, 6'h20), 32'h10, 16'h0001, 1'b0); step();
        check("lu_stall", 32'(last_stall), 32'd1);
        check("lu_bubble_valid", 32'(id_ex_valid), 32'd0);
        check("lu_bubble_ctrl", 32'(id_ex_ctrl), 32'd0);
        step();
        check("lu_stall_once", 32'(last_stall), 32'd0);
        check("lu_add_valid", 32'(id_ex_valid), 32'd1);

        // lw to r0 never stalls.
        issue(i_type(6'h23, 5'd0, 5'd0, 16'h4), 32'h14, 16'h0023, 1'b1); step();
        issue(r_type(5'd0, 5'd0, 5'd4, 6'h20), 32'h18, 16'h0001, 1'b0); step();
        check("lu_r0_nostall", 32'(last_stall), 32'd0);
        check("lu_r0_valid", 32'(id_ex_valid), 32'd1);

        // Immediates and targets.
        issue(i_type(6'h0D, 5'd0, 5'd1, 16'h8000), 32'h1C, 16'h000D, 1'b0); step();
        check("imm_ori", id_ex_imm, 32'h0000_8000);
        issue(i_type(6'h08, 5'd0, 5'd1, 16'h8000), 32'h20, 16'h0008, 1'b0); step();
        check("imm_addi", id_ex_imm, 32'hFFFF_8000);
        issue(i_type(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h100, 16'h0004, 1'b0); step();
        check("beq_target", id_ex_branch_target, 32'h0000_00FC);
        issue({6'h02, 26'h0000040}, 32'h1000_0004, 16'h0002, 1'b0); step();
        check("j_target", id_ex_jump_target, 32'h1000_0100);
        issue(i_type(6'h04, 5'd0, 5'd0, 16'h0001), 32'hFFFF_FFFC, 16'h0004, 1'b0); step();
        check("beq_wrap", id_ex_branch_target, 32'h0000_0000);

        // flush + ex_hold + hazard: flush wins, no stall.
        issue(i_type(6'h23, 5'd0, 5'd9, 16'h0), 32'h30, 16'h0023, 1'b1); step();
        issue(r_type(5'd9, 5'd0, 5'd1, 6'h20), 32'h34, 16'h0001, 1'b0);
        flush = 1'b1; ex_hold = 1'b1; step();
        check("fh_stall", 32'(last_stall), 32'd0);
        check("fh_valid", 32'(id_ex_valid), 32'd0);
        flush = 1'b0; ex_hold = 1'b0;

        // ex_hold alone freezes ID/EX.
        issue(r_type(5'd1, 5'd2, 5'd3, 6'h22), 32'h200, 16'h0055, 1'b0); step();
        issue(r_type(5'd4, 5'd5, 5'd6, 6'h24), 32'h300, 16'h0077, 1'b0);
        ex_hold = 1'b1; step();
        check("hold_stall", 32'(last_stall), 32'd1);
        check("hold_pc", id_ex_pc, 32'h200);
        check("hold_ctrl", 32'(id_ex_ctrl), 32'h55);
        ex_hold = 1'b0;

        // Signed compare: -1 vs 1.
        set_idle();
        wb_reg_write = 1'b1; wb_reg = 5'd10; wb_data = 32'hFFFF_FFFF; step();
        wb_reg = 5'd11; wb_data = 32'h1; step();
        wb_reg_write = 1'b0;
        issue(r_type(5'd10, 5'd11, 5'd12, 6'h2A), 32'h40, 16'h0001, 1'b0); step();
        check("cmp_lt_eq_gt", {29'd0, id_ex_eq, id_ex_lt, id_ex_gt}, 32'b010);

        // Reset while stalled: stall drops once ID/EX is cleared.
        issue(i_type(6'h23, 5'd0, 5'd8, 16'h0), 32'h50, 16'h0023, 1'b1); step();
        issue(r_type(5'd8, 5'd8, 5'd1, 6'h20), 32'h54, 16'h0001, 1'b0); step();
        check("pre_rst_stall", 32'(last_stall), 32'd1);
        Reset = 1'b1; step();
        Reset = 1'b0; step();
        check("post_rst_stall", 32'(last_stall), 32'd0);

        // Randomised traffic over a small register window to hit hazards often.
        repeat (80) begin
            logic [5:0] op;
            case ($urandom_range(0, 4))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h0D;
                3: op = 6'h08;
                default: op = 6'h04;
            endcase
            issue(i_type(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)),
                  $urandom, 16'($urandom), op == 6'h23);
            if_valid     = ($urandom_range(0, 7) != 0);
            flush        = ($urandom_range(0, 7) == 0);
            ex_hold      = ($urandom_range(0, 5) == 0);
            wb_reg_write = ($urandom_range(0, 1) == 1);
            wb_reg       = 5'($urandom_range(0, 3));
            wb_data      = $urandom;
            step();
        end
        set_idle();
        step();

`ifdef DECODE_PERF_EN
        check("stall_count", stall_count, 32'(m_stall_cnt));
        check("flush_count", flush_count, 32'(m_flush_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
